// File: rtl/instr_sequencer.sv
// -----------------------------------------------------------------------------
// instr_sequencer
// Multi-cycle instruction sequencer. It steps through
// IDLE -> FETCH -> DECODE -> EXEC -> (MEM) -> (WB) -> FETCH and drives the
// datapath enables for the decoded instruction class. Memory waits in FETCH
// and MEM are bounded by TIMEOUT. HALT and ERR are terminal until rst.
//
// Parameters
//   TIMEOUT : maximum consecutive mem_ready-low cycles in FETCH/MEM (1..255)
//   CNT_W   : width of the retired-instruction counter
//
// Ports
//   clk, rst            : clock, asynchronous active-high reset
//   start_i             : level, leaves IDLE
//   op_class_i[2:0]     : 0 ALU, 1 LOAD, 2 STORE, 3 BRANCH, 4 HALT, 5-7 illegal
//   branch_taken_i      : branch condition, used in EXEC
//   mem_ready_i         : memory completion strobe
//   mem_req_o, mem_we_o : memory request / write enable
//   ir_load_o, pc_inc_o, pc_load_o, alu_en_o, flag_en_o, rf_we_o, rf_wsel_o
//                       : datapath enables (rf_wsel 0 = ALU, 1 = memory data)
//   state_o[2:0]        : current state encoding
//   busy_o, halted_o, err_o : status
//   instr_count_o       : saturating retired-instruction count
// -----------------------------------------------------------------------------
module instr_sequencer #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [2:0]       op_class_i,
  input  logic             branch_taken_i,
  input  logic             mem_ready_i,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic             ir_load_o,
  output logic             pc_inc_o,
  output logic             pc_load_o,
  output logic             alu_en_o,
  output logic             flag_en_o,
  output logic             rf_we_o,
  output logic             rf_wsel_o,
  output logic [2:0]       state_o,
  output logic             busy_o,
  output logic             halted_o,
  output logic             err_o,
  output logic [CNT_W-1:0] instr_count_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_ERR    = 3'd7
  } state_t;

  localparam logic [2:0] C_ALU    = 3'd0;
  localparam logic [2:0] C_LOAD   = 3'd1;
  localparam logic [2:0] C_STORE  = 3'd2;
  localparam logic [2:0] C_BRANCH = 3'd3;
  localparam logic [2:0] C_HALT   = 3'd4;

  // Wait counter value of the last permitted mem_ready-low cycle.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t             state_q;
  logic [2:0]         class_q;
  logic [7:0]         wait_q;
  logic [CNT_W-1:0]   cnt_q;

  // Saturating increment of the retirement counter.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      return v;
    end else begin
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  // FSM: state, latched class, memory wait counter and retirement counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      class_q <= 3'd0;
      wait_q  <= 8'd0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_q <= S_FETCH;
            wait_q  <= 8'd0;
          end
        end
        S_FETCH: begin
          // mem_ready on the limit cycle wins over the timeout.
          if (mem_ready_i) begin
            state_q <= S_DECODE;
          end else if (wait_q == WAIT_LAST) begin
            state_q <= S_ERR;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end
        S_DECODE: begin
          class_q <= op_class_i;
          case (op_class_i)
            C_ALU, C_LOAD, C_STORE, C_BRANCH: state_q <= S_EXEC;
            C_HALT: begin
              state_q <= S_HALT;
              cnt_q   <= sat_inc(cnt_q);
            end
            default: state_q <= S_ERR;
          endcase
        end
        S_EXEC: begin
          case (class_q)
            C_BRANCH: begin
              state_q <= S_FETCH;
              wait_q  <= 8'd0;
              cnt_q   <= sat_inc(cnt_q);
            end
            C_ALU: state_q <= S_WB;
            C_LOAD, C_STORE: begin
              state_q <= S_MEM;
              wait_q  <= 8'd0;
            end
            default: state_q <= S_ERR;
          endcase
        end
        S_MEM: begin
          if (mem_ready_i) begin
            if (class_q == C_STORE) begin
              state_q <= S_FETCH;
              wait_q  <= 8'd0;
              cnt_q   <= sat_inc(cnt_q);
            end else begin
              state_q <= S_WB;
            end
          end else if (wait_q == WAIT_LAST) begin
            state_q <= S_ERR;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end
        S_WB: begin
          state_q <= S_FETCH;
          wait_q  <= 8'd0;
          cnt_q   <= sat_inc(cnt_q);
        end
        S_HALT:  state_q <= S_HALT;
        S_ERR:   state_q <= S_ERR;
        default: state_q <= S_ERR;
      endcase
    end
  end

  // Output decode from state, latched class and current inputs; each enable
  // belongs to exactly one state so none can be active in two states.
  always_comb begin
    mem_req_o = 1'b0;
    mem_we_o  = 1'b0;
    ir_load_o = 1'b0;
    pc_inc_o  = 1'b0;
    pc_load_o = 1'b0;
    alu_en_o  = 1'b0;
    flag_en_o = 1'b0;
    rf_we_o   = 1'b0;
    rf_wsel_o = 1'b0;
    busy_o    = 1'b0;
    halted_o  = 1'b0;
    err_o     = 1'b0;
    case (state_q)
      S_FETCH: begin
        busy_o    = 1'b1;
        mem_req_o = 1'b1;
        ir_load_o = mem_ready_i;
        pc_inc_o  = mem_ready_i;
      end
      S_DECODE: busy_o = 1'b1;
      S_EXEC: begin
        busy_o    = 1'b1;
        alu_en_o  = 1'b1;
        flag_en_o = (class_q == C_ALU);
        pc_load_o = (class_q == C_BRANCH) && branch_taken_i;
      end
      S_MEM: begin
        busy_o    = 1'b1;
        mem_req_o = 1'b1;
        mem_we_o  = (class_q == C_STORE);
      end
      S_WB: begin
        busy_o    = 1'b1;
        rf_we_o   = 1'b1;
        rf_wsel_o = (class_q == C_LOAD);
      end
      S_HALT:  halted_o = 1'b1;
      S_ERR:   err_o    = 1'b1;
      default: busy_o   = 1'b0;
    endcase
  end

  assign state_o       = state_q;
  assign instr_count_o = cnt_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// -----------------------------------------------------------------------------
// tb_instr_sequencer
// Directed stimulus with hand-computed per-cycle expectations pushed into a
// scoreboard queue; an independent monitor pops and compares on each falling
// clock edge.
// -----------------------------------------------------------------------------
module tb_instr_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  op_class;
  logic        branch_taken;
  logic        mem_ready;
  logic        mem_req, mem_we, ir_load, pc_inc, pc_load, alu_en, flag_en;
  logic        rf_we, rf_wsel, busy, halted, err;
  logic [2:0]  state;
  logic [15:0] instr_count;

  // Output vector order:
  // mem_req mem_we ir_load pc_inc pc_load alu_en flag_en rf_we rf_wsel busy halted err
  localparam logic [11:0] O_NONE   = 12'h000;
  localparam logic [11:0] O_FWAIT  = 12'h804;
  localparam logic [11:0] O_FRDY   = 12'hB04;
  localparam logic [11:0] O_DEC    = 12'h004;
  localparam logic [11:0] O_EXALU  = 12'h064;
  localparam logic [11:0] O_EXPLN  = 12'h044;
  localparam logic [11:0] O_EXBRT  = 12'h0C4;
  localparam logic [11:0] O_MEMLD  = 12'h804;
  localparam logic [11:0] O_MEMST  = 12'hC04;
  localparam logic [11:0] O_WBALU  = 12'h014;
  localparam logic [11:0] O_WBLD   = 12'h01C;
  localparam logic [11:0] O_HALT   = 12'h002;
  localparam logic [11:0] O_ERR    = 12'h001;

  typedef struct {
    string       name;
    logic [2:0]  st;
    logic [11:0] outs;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  instr_sequencer #(.TIMEOUT(15), .CNT_W(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start),
    .op_class_i    (op_class),
    .branch_taken_i(branch_taken),
    .mem_ready_i   (mem_ready),
    .mem_req_o     (mem_req),
    .mem_we_o      (mem_we),
    .ir_load_o     (ir_load),
    .pc_inc_o      (pc_inc),
    .pc_load_o     (pc_load),
    .alu_en_o      (alu_en),
    .flag_en_o     (flag_en),
    .rf_we_o       (rf_we),
    .rf_wsel_o     (rf_wsel),
    .state_o       (state),
    .busy_o        (busy),
    .halted_o      (halted),
    .err_o         (err),
    .instr_count_o (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compare DUT outputs against the oldest expectation.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [11:0] obs;
      e   = sb.pop_front();
      obs = {mem_req, mem_we, ir_load, pc_inc, pc_load, alu_en, flag_en,
             rf_we, rf_wsel, busy, halted, err};
      total = total + 1;
      if (state !== e.st || obs !== e.outs || instr_count !== e.cnt) begin
        bad = bad + 1;
        $display("FAIL %s: got state=%0d outs=%h cnt=%0d, want state=%0d outs=%h cnt=%0d",
                 e.name, state, obs, instr_count, e.st, e.outs, e.cnt);
      end
    end
  end

  // Drive one cycle of inputs and queue the outputs expected during it.
  task automatic cyc(input logic r, input logic s, input logic [2:0] oc,
                     input logic bt, input logic mr, input logic [2:0] est,
                     input logic [11:0] eo, input logic [15:0] ec,
                     input string nm);
    exp_t e;
    rst          = r;
    start        = s;
    op_class     = oc;
    branch_taken = bt;
    mem_ready    = mr;
    e.name = nm; e.st = est; e.outs = eo; e.cnt = ec;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op_class = 3'd0; branch_taken = 1'b0; mem_ready = 1'b0;
    @(posedge clk);
    #1;
    // Reset and idle behaviour
    cyc(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, O_NONE, 16'd0, "reset");
    cyc(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, O_NONE, 16'd0, "idle_hold");
    cyc(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd0, O_NONE, 16'd0, "idle_memrdy_ignored");
    cyc(1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0, O_NONE, 16'd0, "idle_start");
    // ALU
    cyc(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd1, O_FRDY,  16'd0, "alu_fetch");
    cyc(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd2, O_DEC,   16'd0, "alu_decode");
    cyc(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd3, O_EXALU, 16'd0, "alu_exec");
    cyc(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd5, O_WBALU, 16'd0, "alu_wb");
    // LOAD with three wait cycles in MEM
    cyc(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd1, O_FWAIT, 16'd1, "ld_fetch_wait");
    cyc(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd1, O_FRDY,  16'd1, "ld_fetch");
    cyc(1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 3'd2, O_DEC,   16'd1, "ld_decode");
    cyc(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd3, O_EXPLN, 16'd1, "ld_exec");
    for (int i = 0; i < 3; i++)
      cyc(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd4, O_MEMLD, 16'd1, "ld_mem_wait");
    cyc(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd4, O_MEMLD, 16'd1, "ld_mem_ready");
    cyc(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd5, O_WBLD,  16'd1, "ld_wb");
    // STORE
    cyc(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd1, O_FRDY,  16'd2, "st_fetch");
    cyc(1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 3'd2, O_DEC,   16'd2, "st_decode");
    cyc(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd3, O_EXPLN, 16'd2, "st_exec");
    cyc(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd4, O_MEMST, 16'd2, "st_mem");
    // BRANCH taken then not taken
    cyc(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd1, O_FRDY,  16'd3, "brt_fetch");
    cyc(1'b0, 1'b0, 3'd3, 1'b0, 1'b0, 3'd2, O_DEC,   16'd3, "brt_decode");
    cyc(1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 3'd3, O_EXBRT, 16'd3, "brt_exec");
    cyc(1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 3'd1, O_FRDY,  16'd4, "brn_fetch");
    cyc(1'b0, 1'b0, 3'd3, 1'b1, 1'b0, 3'd2, O_DEC,   16'd4, "brn_decode");
    cyc(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd3, O_EXPLN, 16'd4, "brn_exec");
    // Ready on the 15th wait cycle wins over the timeout
    for (int i = 0; i < 14; i++)
      cyc(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd1, O_FWAIT, 16'd5, "lim_fetch_wait");
    cyc(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd1, O_FRDY,  16'd5, "lim_fetch_ready");
    cyc(1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 3'd2, O_DEC,   16'd5, "lim_decode");
    cyc(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd3, O_EXPLN, 16'd5, "lim_exec");
    cyc(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd4, O_MEMLD, 16'd5, "lim_mem");
    // Reset asserted mid-MEM
    cyc(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, O_NONE,  16'd0, "rst_mid_mem");
    cyc(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, O_NONE,  16'd0, "post_rst_idle");
    // FETCH timeout -> ERR, start ignored
    cyc(1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0, O_NONE,  16'd0, "to_start");
    for (int i = 0; i < 15; i++)
      cyc(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd1, O_FWAIT, 16'd0, "to_fetch_wait");
    cyc(1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 3'd7, O_ERR,   16'd0, "to_err");
    cyc(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd7, O_ERR,   16'd0, "to_err_hold");
    cyc(1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 3'd7, O_ERR,   16'd0, "to_err_start");
    // HALT
    cyc(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, O_NONE,  16'd0, "halt_rst");
    cyc(1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0, O_NONE,  16'd0, "halt_start");
    cyc(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd1, O_FRDY,  16'd0, "halt_fetch");
    cyc(1'b0, 1'b0, 3'd4, 1'b0, 1'b0, 3'd2, O_DEC,   16'd0, "halt_decode");
    cyc(1'b0, 1'b1, 3'd0, 1'b0, 1'b1, 3'd6, O_HALT,  16'd1, "halt_state");
    cyc(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd6, O_HALT,  16'd1, "halt_hold");
    // Illegal class -> ERR without retirement
    cyc(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, O_NONE,  16'd0, "ill_rst");
    cyc(1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 3'd0, O_NONE,  16'd0, "ill_start");
    cyc(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 3'd1, O_FRDY,  16'd0, "ill_fetch");
    cyc(1'b0, 1'b0, 3'd6, 1'b0, 1'b0, 3'd2, O_DEC,   16'd0, "ill_decode");
    cyc(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd7, O_ERR,   16'd0, "ill_err");
    cyc(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd7, O_ERR,   16'd0, "ill_err_hold");
    @(negedge clk);
    #1;
    total = total + 1;
    if (sb.size() != 0) begin
      bad = bad + 1;
      $display("FAIL sb_drain: got %0d pending, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 Parameter TIMEOUT, default 15: maximum wait cycles for mem_ready in FETCH or MEM; legal range 1..255.
REQ-002 Parameter CNT_W, default 16: width of the retired-instruction counter.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  level; begins execution from IDLE.
REQ-006 op_class  input  3  decoded class: 0 ALU, 1 LOAD, 2 STORE, 3 BRANCH, 4 HALT, 5-7 illegal.
REQ-007 branch_taken  input  1  branch condition from flag logic, valid in EXEC.
REQ-008 mem_ready  input  1  memory completion strobe.
REQ-009 mem_req  output  1  memory access request.
REQ-010 mem_we  output  1  memory write enable; 1 only for STORE in MEM.
REQ-011 ir_load, pc_inc, pc_load, alu_en, flag_en, rf_we, rf_wsel  output  1 each  datapath enables; rf_wsel 0 = ALU result, 1 = memory data.
REQ-012 state  output  3  current state encoding.
REQ-013 busy, halted, err  output  1 each  status.
REQ-014 instr_count  output  CNT_W  retired-instruction count.

Function
REQ-015 State encoding SHALL be IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, ERR=7; state held in one registered FSM.
REQ-016 IDLE: all enables 0; start=1 -> FETCH next cycle; otherwise stay.
REQ-017 FETCH: mem_req=1, mem_we=0; in any cycle with mem_ready=1, ir_load=1 and pc_inc=1 for that cycle only -> DECODE.
REQ-018 DECODE: one cycle; op_class latched into an internal class register; HALT -> HALT; 5-7 -> ERR; else -> EXEC.
REQ-019 EXEC: alu_en=1 for one cycle; flag_en=1 only for ALU class; BRANCH: pc_load=branch_taken that cycle -> FETCH; ALU -> WB; LOAD/STORE -> MEM.
REQ-020 MEM: mem_req=1, mem_we=1 only for latched STORE; on mem_ready=1: LOAD -> WB, STORE -> FETCH.
REQ-021 WB: rf_we=1 for one cycle; rf_wsel=1 for LOAD, 0 for ALU -> FETCH.
REQ-022 Wait counter SHALL clear on entry to FETCH or MEM and increment each cycle mem_ready=0; when it reaches TIMEOUT with mem_ready still 0 -> ERR next cycle; mem_ready=1 in the same cycle as the limit takes priority (normal transition).
REQ-023 mem_ready outside FETCH/MEM SHALL be ignored.
REQ-024 HALT: halted=1, all enables 0; remains until rst; start ignored.
REQ-025 ERR: err=1, all enables 0; remains until rst.
REQ-026 busy SHALL be 1 in states FETCH..WB, 0 in IDLE/HALT/ERR.
REQ-027 instr_count SHALL increment by 1 on each retirement (WB->FETCH, EXEC(BRANCH)->FETCH, MEM(STORE)->FETCH, DECODE->HALT), saturating at all-ones.
REQ-028 Enables SHALL be decoded from state, latched class, and current inputs only; never asserted in two states simultaneously.

Reset
REQ-029 rst=1 SHALL immediately force state=IDLE, class register=0, wait counter=0, instr_count=0, all outputs 0, regardless of state, including mid-memory-access.
REQ-030 After rst deasserts, the FSM SHALL remain in IDLE until start=1 is sampled on a rising edge.

Verification
REQ-031 ALU: start=1, mem_ready=1 in FETCH, op_class=0 -> states 1,2,3,5,1; flag_en and rf_we each high exactly 1 cycle, rf_wsel=0; instr_count=1.
REQ-032 LOAD with mem_ready delayed 3 cycles in MEM -> mem_req high 4 cycles in MEM, mem_we=0, WB with rf_wsel=1; instr_count increments by 1.
REQ-033 BRANCH with branch_taken=1 -> pc_load=1 for one cycle in EXEC, no rf_we, returns to FETCH; with branch_taken=0 -> pc_load stays 0.
REQ-034 mem_ready held 0 in FETCH for TIMEOUT=15 cycles -> state=7, err=1, mem_req=0; start toggling has no effect until rst.
REQ-035 op_class=4 -> HALT, halted=1, instr_count+1; op_class=6 -> ERR, instr_count unchanged.
REQ-036 rst asserted mid-MEM with mem_req=1 -> same-cycle asynchronous return to IDLE, all outputs 0, instr_count=0.
